filter_test_24: RTL and testbench

// - 24-tap antisymmetric (type IV) FIR differentiator on a stream of signed 16-bit Q8 samples.
// - Produces one registered output sample per enabled clock.
// - Sits in the Differentiator datapath between the sample source and downstream logic.
// - The clock-enable gates all state, so the block can run at a decimated sample rate.

---
 rtl/filter_test_24.sv | 79 +++++++
 tb/tb_filter_test_24.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/filter_test_24.sv
// rtl/filter_test_24.sv - 24-tap antisymmetric FIR differentiator, Q8 in/out, saturating
module filter_test_24 (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic signed [15:0] Input1,
  output logic signed [15:0] Output1
);

  localparam int NTAPS = 24;
  localparam int HALF  = NTAPS / 2;
  localparam int AW    = 37;

  // First half of the impulse response, sfix16_En14 held in 17 bits so the
  // pre-subtracted 17-bit sample pairs multiply without extra casts.
  // The second half is the negated mirror: h[23-k] = -h[k].
  localparam logic signed [16:0] H [0:HALF-1] = '{
    17'sd39,    -17'sd47,   17'sd58,    -17'sd72,
    17'sd93,    -17'sd123,  17'sd172,   -17'sd258,
    17'sd426,   -17'sd834,  17'sd2318,  -17'sd20861
  };

  logic signed [15:0]   dly   [1:NTAPS-1];
  logic signed [15:0]   taps  [0:NTAPS-1];
  logic signed [16:0]   pre;
  logic signed [32:0]   prod;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] shifted;
  logic signed [15:0]   sat;

  // Tap vector: current sample used combinationally, older ones from the delay line
  always_comb begin
    taps[0] = Input1;
    for (int k = 1; k < NTAPS; k++) begin
      taps[k] = dly[k];
    end
  end

  // Folded MAC: x[n-k] - x[n-23+k] times h[k]; exact, identical to the direct form
  always_comb begin
    pre  = '0;
    prod = '0;
    acc  = '0;
    for (int k = 0; k < HALF; k++) begin
      pre  = {taps[k][15], taps[k]} - {taps[NTAPS-1-k][15], taps[NTAPS-1-k]};
      prod = pre * H[k];
      acc  = acc + {{(AW-33){prod[32]}}, prod};
    end
  end

  // En22 -> En8 by flooring shift, then clamp to the 16-bit range
  always_comb begin
    shifted = acc >>> 14;
    if (shifted > 37'sd32767) begin
      sat = 16'sh7FFF;
    end else if (shifted < -37'sd32768) begin
      sat = 16'sh8000;
    end else begin
      sat = shifted[15:0];
    end
  end

  // Delay line and output register advance only on enabled edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k < NTAPS; k++) begin
        dly[k] <= '0;
      end
      Output1 <= '0;
    end else if (clk_enable) begin
      dly[1] <= Input1;
      for (int k = 2; k < NTAPS; k++) begin
        dly[k] <= dly[k-1];
      end
      Output1 <= sat;
    end
  end

endmodule

// File: tb/tb_filter_test_24.sv
// tb/tb_filter_test_24.sv - directed self-checking bench for filter_test_24
module tb_filter_test_24;

  logic               clk;
  logic               reset;
  logic               clk_enable;
  logic signed [15:0] Input1;
  logic signed [15:0] Output1;

  int vectors;
  int miscompares;

  // floor(h[k]/64): response to a single 0x0100 sample
  int imp_exp [24] = '{0, -1, 0, -2, 1, -2, 2, -5, 6, -14, 36, -326,
                       325, -37, 13, -7, 4, -3, 1, -2, 1, -1, 0, -1};
  // floor(running sum of h / 64): response to 0x0100 held
  int step_exp [24] = '{0, -1, 0, -1, 1, -1, 1, -3, 4, -9, 27, -299,
                        27, -9, 4, -3, 1, -1, 1, -1, 0, -1, 0, 0};

  filter_test_24 dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .Input1     (Input1),
    .Output1    (Output1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [15:0] x, input logic en);
    Input1     = x;
    clk_enable = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clk_enable = 1'b0;
    Input1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic impulse_check(input string tag);
    for (int k = 0; k < 24; k++) begin
      sample((k == 0) ? 16'h0100 : 16'h0000, 1'b1);
      check($sformatf("%s[%0d]", tag, k), Output1, 16'(imp_exp[k]));
    end
    for (int k = 24; k < 27; k++) begin
      sample(16'h0000, 1'b1);
      check($sformatf("%s[%0d]", tag, k), Output1, 16'h0000);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    clk_enable  = 1'b0;
    Input1      = '0;
    #2;
    reset = 1'b0;

    // Reset held: output stays clear even with enable and data active
    Input1 = 16'h7ABC;
    clk_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", Output1, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // Idle zeros
    for (int k = 0; k < 4; k++) begin
      sample(16'h0000, 1'b1);
      check($sformatf("idle[%0d]", k), Output1, 16'h0000);
    end

    // Impulse response
    impulse_check("impulse");

    // Step response settles to zero
    do_reset();
    for (int k = 0; k < 30; k++) begin
      sample(16'h0100, 1'b1);
      check($sformatf("step[%0d]", k), Output1, (k < 24) ? 16'(step_exp[k]) : 16'h0000);
    end

    // Nyquist-rate full-scale input saturates without wrap
    do_reset();
    for (int k = 0; k < 40; k++) begin
      sample((k % 2 == 0) ? 16'h7FFF : 16'h8000, 1'b1);
      if (k >= 12) begin
        check($sformatf("sat[%0d]", k), Output1, (k % 2 == 0) ? 16'h7FFF : 16'h8000);
      end
    end

    // Enable gap mid-impulse: output frozen, sequence resumes intact
    do_reset();
    for (int k = 0; k < 6; k++) begin
      sample((k == 0) ? 16'h0100 : 16'h0000, 1'b1);
      check($sformatf("gate_pre[%0d]", k), Output1, 16'(imp_exp[k]));
    end
    for (int g = 0; g < 5; g++) begin
      sample(16'h1234, 1'b0);
      check($sformatf("gate_hold[%0d]", g), Output1, 16'(imp_exp[5]));
    end
    for (int k = 6; k < 24; k++) begin
      sample(16'h0000, 1'b1);
      check($sformatf("gate_post[%0d]", k), Output1, 16'(imp_exp[k]));
    end

    // Asynchronous reset between edges mid-stream
    do_reset();
    for (int k = 0; k < 12; k++) begin
      sample((k == 0) ? 16'h0100 : 16'h0000, 1'b1);
    end
    check("areset_before", Output1, 16'(imp_exp[11]));
    #2;
    reset = 1'b0;
    #1;
    check("areset_now", Output1, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    impulse_check("areset_imp");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
